// File: rtl/mips32_mem_pkg.sv
// Shared constants and types for the MIPS32 unified-memory arbiter.
package mips32_mem_pkg;

  // Port identifiers; also used as bit indices into 2-bit request/grant vectors.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Supported memory read latency range and the counter width it needs.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mips32_mem_arbiter_rr.sv
// Two-requester round-robin arbiter with an enable; remembers the last winner.
module rr_arbiter2
  import mips32_mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic [1:0] req_i,      // indexed by port id
  output logic [1:0] gnt_o,      // one-hot grant, indexed by port id
  output logic       gnt_any_o,
  output logic       gnt_id_o
);

  logic last_gnt_q, last_gnt_d;
  logic win;

  // Pick the winner: a lone requester, or on a tie the port not served last.
  always_comb begin
    gnt_o      = 2'b00;
    gnt_any_o  = 1'b0;
    win        = PORT_IF;
    last_gnt_d = last_gnt_q;
    if (en_i && (req_i != 2'b00)) begin
      if (req_i == 2'b11) win = ~last_gnt_q;
      else                win = req_i[PORT_DM];
      gnt_any_o  = 1'b1;
      gnt_o[win] = 1'b1;
      last_gnt_d = win;
    end
    gnt_id_o = win;
  end

  // Last-winner register; DM after reset so fetch wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_gnt_q <= PORT_DM;
    else          last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data load/store, one outstanding read at a time, with a contention counter.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic       ret_cycle, arb_en, gnt_any, gnt_id, gnt_write, conflict_hit;
  logic [1:0] gnt;

  // The return cycle of a read doubles as an arbitration slot (back-to-back).
  // Grants are suppressed while reset is held so every output reads 0.
  assign ret_cycle = (state_q == ST_WAIT) && (lat_cnt_q == LAT_W'(1));
  assign arb_en    = reset_n && ((state_q == ST_IDLE) || ret_cycle);

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .en_i      (arb_en),
    .req_i     ({dm_req, if_req}),
    .gnt_o     (gnt),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

  assign if_gnt    = gnt[PORT_IF];
  assign dm_gnt    = gnt[PORT_DM];
  assign gnt_write = gnt_any && (gnt_id == PORT_DM) && dm_we;

  // Steer the granted port onto the memory bus; bus idles at zero otherwise.
  always_comb begin
    mem_en    = gnt_any;
    mem_we    = gnt_write;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (gnt_any)   mem_addr  = (gnt_id == PORT_DM) ? dm_addr : if_addr;
    if (gnt_write) mem_wdata = dm_wdata;
  end

  // Read data is a pass-through, qualified only by the owner's rvalid.
  assign if_rvalid = ret_cycle && (owner_q == PORT_IF);
  assign dm_rvalid = ret_cycle && (owner_q == PORT_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  // Next state: count down an outstanding read; a granted read (re)arms WAIT.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    if (state_q == ST_WAIT) begin
      lat_cnt_d = lat_cnt_q - LAT_W'(1);
      if (ret_cycle) state_d = ST_IDLE;
    end
    if (gnt_any && !gnt_write) begin
      state_d   = ST_WAIT;
      lat_cnt_d = LAT_W'(MEM_LAT);
      owner_d   = gnt_id;
    end
  end

  // Contention: both ports asking, or anyone asking while the bus is busy.
  always_comb begin
    conflict_hit   = (if_req && dm_req) ||
                     ((if_req || dm_req) && (state_q == ST_WAIT) && (lat_cnt_q > LAT_W'(1)));
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_hit && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  assign conflict_cnt = conflict_cnt_q;

  // State, latency counter, owner and contention counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      lat_cnt_q      <= '0;
      owner_q        <= PORT_IF;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      owner_q        <= owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench: three arbiter instances (MEM_LAT 1/3/4, CNT_W 16/16/4),
// directed scenarios plus randomized traffic against a cycle-level model.
module tb_mips32_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req [3];
  logic [31:0] if_addr [3];
  logic        if_gnt [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata [3];
  logic        dm_req [3];
  logic        dm_we [3];
  logic [31:0] dm_addr [3];
  logic [31:0] dm_wdata [3];
  logic        dm_gnt [3];
  logic        dm_rvalid [3];
  logic [31:0] dm_rdata [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [15:0] cnt [3];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory contents as a fixed function of address (instance-salted).
  function automatic logic [31:0] mem_f(input logic [31:0] a, input int k);
    logic [31:0] h;
    if (a == 32'h4) return 32'h2008_0005;
    h = (a ^ 32'hA5A5_0000) * 32'd2654435761;
    return h + 32'(k);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L  = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    localparam int CW = (gi == 2) ? 4 : 16;
    logic [CW-1:0] cnt_l;
    logic [31:0]   mrd;
    logic          pv = 1'b0;
    int            pdue = 0;
    logic [31:0]   pdata = 32'h0;

    mips32_mem_arbiter #(.MEM_LAT(L), .CNT_W(CW)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .if_req       (if_req[gi]),
      .if_addr      (if_addr[gi]),
      .if_gnt       (if_gnt[gi]),
      .if_rvalid    (if_rvalid[gi]),
      .if_rdata     (if_rdata[gi]),
      .dm_req       (dm_req[gi]),
      .dm_we        (dm_we[gi]),
      .dm_addr      (dm_addr[gi]),
      .dm_wdata     (dm_wdata[gi]),
      .dm_gnt       (dm_gnt[gi]),
      .dm_rvalid    (dm_rvalid[gi]),
      .dm_rdata     (dm_rdata[gi]),
      .mem_en       (mem_en[gi]),
      .mem_we       (mem_we[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_wdata    (mem_wdata[gi]),
      .mem_rdata    (mrd),
      .conflict_cnt (cnt_l)
    );

    assign cnt[gi] = 16'(cnt_l);
    // Fixed-latency memory: data valid exactly L cycles after a read access.
    assign mrd = (pv && (pdue == cyc)) ? pdata : {16'hBAD0, cyc[15:0]};
    always @(posedge clock) begin
      if (mem_en[gi] === 1'b1 && mem_we[gi] === 1'b0) begin
        pv    <= 1'b1;
        pdue  <= cyc + L;
        pdata <= mem_f(mem_addr[gi], gi);
      end
    end
  end

  // Reference model: per instance, the cycle its outstanding read returns.
  int          m_ret [3];
  int          m_owner [3];
  int          m_last [3];
  int          m_cnt [3];
  logic [31:0] m_data [3];
  int          e_cyc, e_win;
  logic        e_ifg, e_dmg, e_en, e_we, e_ifv, e_dmv, e_inc;
  logic [31:0] e_addr, e_wdata, e_rdata;
  int          e_cnt;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ret[k] = -1; m_owner[k] = 0; m_last[k] = 1; m_cnt[k] = 0; m_data[k] = 32'h0;
    end
  endfunction

  function automatic void model_eval(input int k);
    logic any, both, free;
    e_cyc = cyc;
    any   = if_req[k] | dm_req[k];
    both  = if_req[k] & dm_req[k];
    free  = (m_ret[k] <= e_cyc);
    e_ifv = (m_ret[k] == e_cyc) && (m_owner[k] == 0);
    e_dmv = (m_ret[k] == e_cyc) && (m_owner[k] == 1);
    e_rdata = m_data[k];
    e_cnt = m_cnt[k];
    e_inc = both || (any && !free);
    e_win = -1; e_ifg = 0; e_dmg = 0; e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    if (free && any) begin
      if (both) e_win = 1 - m_last[k];
      else      e_win = if_req[k] ? 0 : 1;
      e_en = 1;
      if (e_win == 0) begin
        e_ifg = 1; e_addr = if_addr[k];
      end else begin
        e_dmg = 1; e_addr = dm_addr[k]; e_we = dm_we[k];
        if (dm_we[k]) e_wdata = dm_wdata[k];
      end
    end
  endfunction

  function automatic void model_commit(input int k);
    if (e_inc && m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
    if (e_win >= 0) begin
      m_last[k] = e_win;
      if (!e_we) begin
        m_ret[k]   = e_cyc + lat_of(k);
        m_owner[k] = e_win;
        m_data[k]  = mem_f(e_addr, k);
      end
    end
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_all();
    for (int k = 0; k < 3; k++) begin if_req[k] = 1; dm_req[k] = 1; dm_addr[k] = 32'h44; end
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({if_gnt[k], dm_gnt[k], if_rvalid[k], dm_rvalid[k], mem_en[k], mem_we[k]} !== 6'b0) begin
        failures++; $display("FAIL reset_ctrl k=%0d got=%b exp=000000", k,
          {if_gnt[k], dm_gnt[k], if_rvalid[k], dm_rvalid[k], mem_en[k], mem_we[k]});
      end
      checks++;
      if (mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0 || cnt[k] !== 16'h0) begin
        failures++; $display("FAIL reset_data k=%0d addr=%h wdata=%h cnt=%0d exp=0", k, mem_addr[k], mem_wdata[k], cnt[k]);
      end
    end
    $display("txn reset: all instances held in reset with requests asserted");
    do_reset();
  endtask

  task automatic test_read_only();
    do_reset();
    if_req[0] = 1; if_addr[0] = 32'h0000_0004;
    @(negedge clock);
    checks++;
    if ({if_gnt[0], mem_en[0], mem_we[0], dm_gnt[0]} !== 4'b1100 || mem_addr[0] !== 32'h4) begin
      failures++; $display("FAIL ro_grant gnt/en/we/dgnt=%b addr=%h exp=1100 addr=4",
        {if_gnt[0], mem_en[0], mem_we[0], dm_gnt[0]}, mem_addr[0]);
    end
    $display("txn ro: fetch addr=00000004 issued");
    tick(); if_req[0] = 0;
    @(negedge clock);
    checks++;
    if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'h2008_0005) begin
      failures++; $display("FAIL ro_return rvalid=%b rdata=%h exp 1 20080005", if_rvalid[0], if_rdata[0]);
    end
    checks++;
    if (dm_rvalid[0] !== 1'b0) begin failures++; $display("FAIL ro_dm_rvalid got=%b exp=0", dm_rvalid[0]); end
    tick(); @(negedge clock);
    checks++;
    if (if_rvalid[0] !== 1'b0) begin failures++; $display("FAIL ro_rvalid_drop got=%b exp=0", if_rvalid[0]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req[0] = 1; if_addr[0] = 32'h8; dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h10;
    @(negedge clock);
    checks++;
    if ({if_gnt[0], dm_gnt[0]} !== 2'b10) begin failures++; $display("FAIL sim_first got=%b exp=10", {if_gnt[0], dm_gnt[0]}); end
    tick(); if_req[0] = 0;
    @(negedge clock);
    checks++;
    if ({if_rvalid[0], dm_gnt[0]} !== 2'b11) begin failures++; $display("FAIL sim_second rvalid/dgnt=%b exp=11", {if_rvalid[0], dm_gnt[0]}); end
    checks++;
    if (cnt[0] !== 16'd1) begin failures++; $display("FAIL sim_cnt got=%0d exp=1", cnt[0]); end
    $display("txn sim: IF then DM granted");
    tick(); dm_req[0] = 0;
    @(negedge clock);
    checks++;
    if (dm_rvalid[0] !== 1'b1 || dm_rdata[0] !== mem_f(32'h10, 0)) begin
      failures++; $display("FAIL sim_dm_data rvalid=%b rdata=%h exp 1 %h", dm_rvalid[0], dm_rdata[0], mem_f(32'h10, 0));
    end
  endtask

  task automatic test_lat3();
    do_reset();
    dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'h30;
    @(negedge clock);
    checks++;
    if (dm_gnt[1] !== 1'b1) begin failures++; $display("FAIL l3_dm_gnt got=%b exp=1", dm_gnt[1]); end
    tick(); dm_req[1] = 0; if_req[1] = 1; if_addr[1] = 32'h40;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clock);
      checks++;
      if (if_gnt[1] !== 1'b0 || dm_rvalid[1] !== 1'b0) begin
        failures++; $display("FAIL l3_denied t+%0d gnt=%b rvalid=%b exp 0 0", i, if_gnt[1], dm_rvalid[1]);
      end
      tick();
    end
    @(negedge clock);
    checks++;
    if ({dm_rvalid[1], if_gnt[1]} !== 2'b11 || dm_rdata[1] !== mem_f(32'h30, 1)) begin
      failures++; $display("FAIL l3_return rvalid/gnt=%b rdata=%h exp 11 %h", {dm_rvalid[1], if_gnt[1]}, dm_rdata[1], mem_f(32'h30, 1));
    end
    tick(); if_req[1] = 0;
    @(negedge clock);
    checks++;
    if (cnt[1] !== 16'd2) begin failures++; $display("FAIL l3_cnt got=%0d exp=2", cnt[1]); end
    $display("txn l3: DM load then IF after denial");
  endtask

  task automatic test_store();
    do_reset();
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h20; dm_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++;
    if ({dm_gnt[0], mem_en[0], mem_we[0]} !== 3'b111 || mem_wdata[0] !== 32'hDEAD_BEEF || mem_addr[0] !== 32'h20) begin
      failures++; $display("FAIL st_write gnt/en/we=%b addr=%h wdata=%h exp 111 20 deadbeef",
        {dm_gnt[0], mem_en[0], mem_we[0]}, mem_addr[0], mem_wdata[0]);
    end
    tick(); dm_req[0] = 0; dm_we[0] = 0; if_req[0] = 1; if_addr[0] = 32'h24;
    @(negedge clock);
    checks++;
    if ({if_gnt[0], dm_rvalid[0], mem_we[0]} !== 3'b100) begin
      failures++; $display("FAIL st_next_fetch gnt/drv/we=%b exp=100", {if_gnt[0], dm_rvalid[0], mem_we[0]});
    end
    tick(); if_req[0] = 0;
    @(negedge clock);
    checks++;
    if ({if_rvalid[0], dm_rvalid[0]} !== 2'b10) begin failures++; $display("FAIL st_rvalid got=%b exp=10", {if_rvalid[0], dm_rvalid[0]}); end
    $display("txn st: store deadbeef to 00000020 then fetch");
  endtask

  task automatic test_back_to_back();
    int n_if = 0, n_dm = 0;
    do_reset();
    if_req[0] = 1; if_addr[0] = 32'h100; dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (if_gnt[0] !== ((i % 2) == 0) || dm_gnt[0] !== ((i % 2) == 1)) begin
        failures++; $display("FAIL b2b_alt cyc%0d got=%b exp=%b", i, {if_gnt[0], dm_gnt[0]}, ((i % 2) == 0) ? 2'b10 : 2'b01);
      end
      if (if_gnt[0] === 1'b1) n_if++;
      if (dm_gnt[0] === 1'b1) n_dm++;
      tick();
    end
    idle_all();
    checks++;
    if (n_if != 4 || n_dm != 4) begin failures++; $display("FAIL b2b_count if=%0d dm=%0d exp 4 4", n_if, n_dm); end
    $display("txn b2b: if_grants=%0d dm_grants=%0d", n_if, n_dm);
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    do_reset();
    if_req[2] = 1; if_addr[2] = 32'h50;
    tick(); if_req[2] = 0;
    tick();
    reset_n = 1'b0;
    if_req[2] = 1; dm_req[2] = 1; dm_addr[2] = 32'h60; dm_wdata[2] = 32'h1234_5678;
    #1;
    checks++;
    if ({if_gnt[2], dm_gnt[2], if_rvalid[2], dm_rvalid[2], mem_en[2], mem_we[2]} !== 6'b0 ||
        mem_addr[2] !== 32'h0 || mem_wdata[2] !== 32'h0 || cnt[2] !== 16'h0) begin
      failures++; $display("FAIL rmw_outputs ctl=%b addr=%h wdata=%h cnt=%0d exp all 0",
        {if_gnt[2], dm_gnt[2], if_rvalid[2], dm_rvalid[2], mem_en[2], mem_we[2]}, mem_addr[2], mem_wdata[2], cnt[2]);
    end
    if_req[2] = 0; dm_req[2] = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (if_rvalid[2] === 1'b1 || dm_rvalid[2] === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rmw_no_rvalid got=%0d exp=0", seen); end
    if_req[2] = 1; if_addr[2] = 32'h70; dm_req[2] = 1; dm_addr[2] = 32'h74;
    @(negedge clock);
    checks++;
    if ({if_gnt[2], dm_gnt[2]} !== 2'b10) begin failures++; $display("FAIL rmw_tie got=%b exp=10", {if_gnt[2], dm_gnt[2]}); end
    tick(); idle_all();
    $display("txn rmw: read abandoned by reset, tie goes to IF");
  endtask

  task automatic test_saturation();
    do_reset();
    if_req[2] = 1; if_addr[2] = 32'h80; dm_req[2] = 1; dm_we[2] = 0; dm_addr[2] = 32'h84;
    repeat (14) @(posedge clock);
    @(negedge clock);
    checks++;
    if (cnt[2] !== 16'd14) begin failures++; $display("FAIL sat_mid got=%0d exp=14", cnt[2]); end
    repeat (6) @(posedge clock);
    @(negedge clock);
    checks++;
    if (cnt[2] !== 16'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", cnt[2]); end
    #1 idle_all();
    $display("txn sat: conflict_cnt=%0d after 20 contended cycles", cnt[2]);
  endtask

  task automatic test_random(input int k, input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      if (!if_req[k] && $urandom_range(1, 0) == 1) begin
        if_req[k] = 1; if_addr[k] = 32'($urandom_range(255, 0)) << 2;
      end
      if (!dm_req[k] && $urandom_range(1, 0) == 1) begin
        dm_req[k] = 1; dm_we[k] = ($urandom_range(2, 0) == 0);
        dm_addr[k] = 32'($urandom_range(255, 0)) << 2; dm_wdata[k] = $urandom;
      end
      @(negedge clock);
      model_eval(k);
      checks++;
      if ({if_gnt[k], dm_gnt[k], mem_en[k]} !== {e_ifg, e_dmg, e_en}) begin
        failures++; $display("FAIL rnd_gnt k=%0d i=%0d got=%b exp=%b", k, i, {if_gnt[k], dm_gnt[k], mem_en[k]}, {e_ifg, e_dmg, e_en});
      end
      checks++;
      if (e_en && (mem_we[k] !== e_we || mem_addr[k] !== e_addr || (e_we && mem_wdata[k] !== e_wdata))) begin
        failures++; $display("FAIL rnd_bus k=%0d i=%0d we=%b addr=%h wd=%h exp %b %h %h", k, i, mem_we[k], mem_addr[k], mem_wdata[k], e_we, e_addr, e_wdata);
      end
      checks++;
      if ({if_rvalid[k], dm_rvalid[k]} !== {e_ifv, e_dmv}) begin
        failures++; $display("FAIL rnd_rvalid k=%0d i=%0d got=%b exp=%b", k, i, {if_rvalid[k], dm_rvalid[k]}, {e_ifv, e_dmv});
      end
      checks++;
      if ((e_ifv && if_rdata[k] !== e_rdata) || (e_dmv && dm_rdata[k] !== e_rdata)) begin
        failures++; $display("FAIL rnd_rdata k=%0d i=%0d if=%h dm=%h exp=%h", k, i, if_rdata[k], dm_rdata[k], e_rdata);
      end
      checks++;
      if (int'(cnt[k]) != e_cnt) begin failures++; $display("FAIL rnd_cnt k=%0d i=%0d got=%0d exp=%0d", k, i, cnt[k], e_cnt); end
      if (e_en) $display("txn rnd k=%0d cyc=%0d port=%s we=%b addr=%h", k, e_cyc, (e_win == 0) ? "IF" : "DM", e_we, e_addr);
      @(posedge clock);
      model_commit(k);
      #1;
      if (e_ifg) if_req[k] = 0;
      if (e_dmg) dm_req[k] = 0;
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_read_only();
    test_simultaneous();
    test_lat3();
    test_store();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    for (int k = 0; k < 3; k++) test_random(k, 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
